// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the hazard controller: RV32I opcodes, forwarding
// select codes, FSM state encodings and operand-use decode helpers.
package hazard_ctrl_pkg;

  localparam int OPLEN = 7;
  localparam int XADDR = 5;

  localparam logic [OPLEN-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPLEN-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPLEN-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPLEN-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPLEN-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPLEN-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPLEN-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPLEN-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPLEN-1:0] OP_REG    = 7'b0110011;
  localparam logic [OPLEN-1:0] OP_SYSTEM = 7'b1110011;

  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_MEM = 2'b01;
  localparam fwd_sel_t FWD_WB  = 2'b10;

  typedef enum logic [2:0] {
    HZ_RUN        = 3'd0,
    HZ_LOAD_STALL = 3'd1,
    HZ_FLUSH      = 3'd2,
    HZ_MEM_WAIT   = 3'd3,
    HZ_DRAIN      = 3'd4
  } hz_state_e;

  function automatic logic uses_rs1(input logic [OPLEN-1:0] op);
    return (op == OP_JALR) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_IMM) || (op == OP_REG) ||
           (op == OP_SYSTEM);
  endfunction

  function automatic logic uses_rs2(input logic [OPLEN-1:0] op);
    return (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_REG);
  endfunction

  // The youngest producer (EX) wins over the older one in MEM.
  function automatic fwd_sel_t fwd_select(input logic hit_ex, input logic hit_mem);
    if (hit_ex)  return FWD_MEM;
    if (hit_mem) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline (master) and the hazard controller (slave).
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [OPLEN-1:0] i_id_opcode;
  logic [XADDR-1:0] i_id_rs1_addr;
  logic [XADDR-1:0] i_id_rs2_addr;
  logic [XADDR-1:0] i_ex_rd_addr;
  logic             i_ex_wr_en;
  logic             i_ex_is_load;
  logic [XADDR-1:0] i_mem_rd_addr;
  logic             i_mem_wr_en;
  logic             i_wb_wr_en;
  logic             i_branch_taken;
  logic             i_mem_busy;

  logic             or_stall_if;
  logic             or_stall_id;
  logic             or_stall_ex;
  logic             or_flush_id;
  logic             or_flush_ex;
  logic [1:0]       or_fwd_a;
  logic [1:0]       or_fwd_b;
  logic [2:0]       or_state;

  modport slave (
    input  i_id_opcode, i_id_rs1_addr, i_id_rs2_addr, i_ex_rd_addr, i_ex_wr_en,
           i_ex_is_load, i_mem_rd_addr, i_mem_wr_en, i_wb_wr_en, i_branch_taken,
           i_mem_busy,
    output or_stall_if, or_stall_id, or_stall_ex, or_flush_id, or_flush_ex,
           or_fwd_a, or_fwd_b, or_state
  );

  modport master (
    output i_id_opcode, i_id_rs1_addr, i_id_rs2_addr, i_ex_rd_addr, i_ex_wr_en,
           i_ex_is_load, i_mem_rd_addr, i_mem_wr_en, i_wb_wr_en, i_branch_taken,
           i_mem_busy,
    input  or_stall_if, or_stall_id, or_stall_ex, or_flush_id, or_flush_ex,
           or_fwd_a, or_fwd_b, or_state
  );

endinterface

// File: rtl/hazard_match.sv
// One source/destination dependency comparator; x0 never creates a dependency.
module hazard_match
  import hazard_ctrl_pkg::*;
(
  input  logic [XADDR-1:0] i_src_addr,
  input  logic             i_src_used,
  input  logic [XADDR-1:0] i_dst_addr,
  input  logic             i_dst_wr_en,
  output logic             o_match
);

  assign o_match = i_src_used && i_dst_wr_en &&
                   (i_src_addr == i_dst_addr) && (i_src_addr != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencing and registered EX forwarding selects for the RV32I core.
// Define HAZARD_CSR_DRAIN_EN to hold SYSTEM instructions in ID until writes retire.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  hazard_ctrl_if.slave  hz
);

  // Cycles spent in FLUSH after the detecting cycle has already flushed once.
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  hz_state_e  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  fwd_sel_t   fwd_a_q, fwd_a_d;
  fwd_sel_t   fwd_b_q, fwd_b_d;

  logic rs1_used, rs2_used;
  logic hit_a_ex, hit_a_mem, hit_b_ex, hit_b_mem;
  logic load_use, branch, run_eval;
  logic stall_if, stall_id, stall_ex, flush_id, flush_ex;

  assign rs1_used = uses_rs1(hz.i_id_opcode);
  assign rs2_used = uses_rs2(hz.i_id_opcode);

  hazard_match u_match_a_ex (
    .i_src_addr (hz.i_id_rs1_addr), .i_src_used (rs1_used),
    .i_dst_addr (hz.i_ex_rd_addr),  .i_dst_wr_en(hz.i_ex_wr_en),  .o_match(hit_a_ex)
  );
  hazard_match u_match_a_mem (
    .i_src_addr (hz.i_id_rs1_addr), .i_src_used (rs1_used),
    .i_dst_addr (hz.i_mem_rd_addr), .i_dst_wr_en(hz.i_mem_wr_en), .o_match(hit_a_mem)
  );
  hazard_match u_match_b_ex (
    .i_src_addr (hz.i_id_rs2_addr), .i_src_used (rs2_used),
    .i_dst_addr (hz.i_ex_rd_addr),  .i_dst_wr_en(hz.i_ex_wr_en),  .o_match(hit_b_ex)
  );
  hazard_match u_match_b_mem (
    .i_src_addr (hz.i_id_rs2_addr), .i_src_used (rs2_used),
    .i_dst_addr (hz.i_mem_rd_addr), .i_dst_wr_en(hz.i_mem_wr_en), .o_match(hit_b_mem)
  );

  assign load_use = hz.i_ex_is_load && (hit_a_ex || hit_b_ex);

`ifdef HAZARD_CSR_DRAIN_EN
  logic drain_req;
  assign drain_req = (hz.i_id_opcode == OP_SYSTEM) &&
                     (hz.i_ex_wr_en || hz.i_mem_wr_en || hz.i_wb_wr_en);
`else
  logic unused_wb_wr_en;
  assign unused_wb_wr_en = hz.i_wb_wr_en;
`endif

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    stall_if = 1'b0;
    stall_id = 1'b0;
    stall_ex = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    run_eval = 1'b0;
    branch   = hz.i_branch_taken;

    case (state_q)
      HZ_FLUSH: begin
        // Busy and branches are ignored until the flush window closes.
        flush_id = 1'b1;
        flush_ex = 1'b1;
        if (cnt_q <= 2'd1) begin
          cnt_d   = 2'd0;
          state_d = hz.i_mem_busy ? HZ_MEM_WAIT : HZ_RUN;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      HZ_MEM_WAIT: begin
        if (hz.i_mem_busy) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
          pend_d   = pend_q | hz.i_branch_taken;
        end else begin
          run_eval = 1'b1;
          branch   = hz.i_branch_taken | pend_q;
        end
      end
      default: run_eval = 1'b1;
    endcase

    if (run_eval) begin
      if (hz.i_mem_busy) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
        pend_d   = hz.i_branch_taken;
        state_d  = HZ_MEM_WAIT;
      end else if (branch) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
        pend_d   = 1'b0;
        if (FLUSH_LOAD != 2'd0) begin
          cnt_d   = FLUSH_LOAD;
          state_d = HZ_FLUSH;
        end else begin
          state_d = HZ_RUN;
        end
      end else if (load_use) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
        state_d  = HZ_LOAD_STALL;
`ifdef HAZARD_CSR_DRAIN_EN
      end else if (drain_req) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
        state_d  = HZ_DRAIN;
`endif
      end else begin
        state_d = HZ_RUN;
      end
    end
  end

  always_comb begin
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (flush_ex) begin
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
    end else if (!stall_ex) begin
      fwd_a_d = fwd_select(hit_a_ex, hit_a_mem);
      fwd_b_d = fwd_select(hit_b_ex, hit_b_mem);
    end
  end

  // NOTE: reset is sampled on the clock edge only, and all state updates use <=.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= HZ_RUN;
      cnt_q   <= 2'd0;
      pend_q  <= 1'b0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  // Controls are held quiet while reset is asserted.
  assign hz.or_stall_if = i_rst_n & stall_if;
  assign hz.or_stall_id = i_rst_n & stall_id;
  assign hz.or_stall_ex = i_rst_n & stall_ex;
  assign hz.or_flush_id = i_rst_n & flush_id;
  assign hz.or_flush_ex = i_rst_n & flush_ex;
  assign hz.or_fwd_a    = fwd_a_q;
  assign hz.or_fwd_b    = fwd_b_q;
  assign hz.or_state    = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed pipeline scenarios then random
// traffic, compared cycle by cycle against a behavioural reference model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int FC = 2;
`ifdef HAZARD_CSR_DRAIN_EN
  localparam bit DRAIN_EN = 1'b1;
`else
  localparam bit DRAIN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if hz();

  hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .hz     (hz)
  );

  typedef struct packed {
    logic       rst_n;
    logic [6:0] op;
    logic [4:0] rs1, rs2, ex_rd, mem_rd;
    logic       ex_we, ex_ld, mem_we, wb_we, taken, busy;
  } stim_t;

  // Observation vector: stall_if, stall_id, stall_ex, flush_id, flush_ex, fwd_a, fwd_b, state
  logic [11:0] exp_q[$];
  string       tag_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference model: state numbers follow the debug encoding of or_state.
  int         m_mode;
  int         m_left;
  bit         m_pend;
  logic [1:0] m_fa, m_fb;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, got[11:0], want[11:0], $time);
    end
  endtask

  function automatic bit reads_rs1(input logic [6:0] op);
    return bit'(op inside {OP_JALR, OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM, OP_REG, OP_SYSTEM});
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return bit'(op inside {OP_STORE, OP_BRANCH, OP_REG});
  endfunction

  function automatic bit dep(input logic [4:0] src, input bit used,
                             input logic [4:0] dst, input bit we);
    return used && we && (src == dst) && (src != 5'd0);
  endfunction

  function automatic logic [1:0] pick(input bit from_ex, input bit from_mem);
    return from_ex ? 2'b01 : (from_mem ? 2'b10 : 2'b00);
  endfunction

  function automatic stim_t idle();
    stim_t s = '0;
    s.rst_n = 1'b1;
    s.op    = OP_IMM;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s = idle();
    case ($urandom_range(0, 10))
      0: s.op = OP_LUI;    1: s.op = OP_AUIPC;  2: s.op = OP_JAL;
      3: s.op = OP_JALR;   4: s.op = OP_BRANCH; 5: s.op = OP_LOAD;
      6: s.op = OP_STORE;  7: s.op = OP_IMM;    8: s.op = OP_REG;
      9: s.op = OP_SYSTEM; default: s.op = 7'b0001111;
    endcase
    s.rs1    = 5'($urandom_range(0, 3));
    s.rs2    = 5'($urandom_range(0, 3));
    s.ex_rd  = 5'($urandom_range(0, 3));
    s.mem_rd = 5'($urandom_range(0, 3));
    s.ex_we  = ($urandom_range(0, 9) < 6);
    s.ex_ld  = ($urandom_range(0, 9) < 4);
    s.mem_we = ($urandom_range(0, 9) < 6);
    s.wb_we  = ($urandom_range(0, 9) < 5);
    s.taken  = ($urandom_range(0, 99) < 8);
    s.busy   = ($urandom_range(0, 99) < 15);
    s.rst_n  = ($urandom_range(0, 99) != 0);
    return s;
  endfunction

  // Drive one cycle of inputs, queue what the DUT must show this cycle, advance the model.
  task automatic step(input stim_t s, input string tag);
    bit sif = 0, sid = 0, sex = 0, fid = 0, fex = 0;
    bit u1, u2, lu, drain, br;
    int nmode = m_mode, nleft = m_left;
    bit npend = m_pend;
    logic [1:0] nfa = m_fa, nfb = m_fb;

    rst_n             = s.rst_n;
    hz.i_id_opcode    = s.op;
    hz.i_id_rs1_addr  = s.rs1;
    hz.i_id_rs2_addr  = s.rs2;
    hz.i_ex_rd_addr   = s.ex_rd;
    hz.i_ex_wr_en     = s.ex_we;
    hz.i_ex_is_load   = s.ex_ld;
    hz.i_mem_rd_addr  = s.mem_rd;
    hz.i_mem_wr_en    = s.mem_we;
    hz.i_wb_wr_en     = s.wb_we;
    hz.i_branch_taken = s.taken;
    hz.i_mem_busy     = s.busy;

    if (!s.rst_n) begin
      nmode = 0; nleft = 0; npend = 0; nfa = 2'b00; nfb = 2'b00;
    end else begin
      u1    = reads_rs1(s.op);
      u2    = reads_rs2(s.op);
      lu    = s.ex_ld && (dep(s.rs1, u1, s.ex_rd, s.ex_we) || dep(s.rs2, u2, s.ex_rd, s.ex_we));
      drain = DRAIN_EN && (s.op == OP_SYSTEM) && (s.ex_we || s.mem_we || s.wb_we);
      if (m_mode == 2) begin
        fid = 1; fex = 1;
        if (m_left > 1) nleft = m_left - 1;
        else begin nleft = 0; nmode = s.busy ? 3 : 0; end
      end else if (m_mode == 3 && s.busy) begin
        sif = 1; sid = 1; sex = 1;
        npend = m_pend || s.taken;
      end else begin
        br = s.taken || (m_mode == 3 && m_pend);
        if (s.busy) begin
          sif = 1; sid = 1; sex = 1; npend = s.taken; nmode = 3;
        end else if (br) begin
          fid = 1; fex = 1; npend = 0;
          if (FC > 1) begin nmode = 2; nleft = FC - 1; end
          else nmode = 0;
        end else if (lu) begin
          sif = 1; sid = 1; fex = 1; nmode = 1;
        end else if (drain) begin
          sif = 1; sid = 1; fex = 1; nmode = 4;
        end else begin
          nmode = 0;
        end
      end
      if (fex) begin
        nfa = 2'b00; nfb = 2'b00;
      end else if (!sex) begin
        nfa = pick(dep(s.rs1, u1, s.ex_rd, s.ex_we), dep(s.rs1, u1, s.mem_rd, s.mem_we));
        nfb = pick(dep(s.rs2, u2, s.ex_rd, s.ex_we), dep(s.rs2, u2, s.mem_rd, s.mem_we));
      end
    end

    exp_q.push_back({sif, sid, sex, fid, fex, m_fa, m_fb, 3'(m_mode)});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    m_mode = nmode; m_left = nleft; m_pend = npend; m_fa = nfa; m_fb = nfb;
  endtask

  // Monitor: compare whatever the DUT presents mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [11:0] want;
      string       name;
      want = exp_q.pop_front();
      name = tag_q.pop_front();
      check(name, 32'({hz.or_stall_if, hz.or_stall_id, hz.or_stall_ex, hz.or_flush_id,
                       hz.or_flush_ex, hz.or_fwd_a, hz.or_fwd_b, hz.or_state}), 32'(want));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst_n = 1'b0;
    rst_n = 1'b0;
    hz.i_id_opcode = OP_IMM;   hz.i_id_rs1_addr = '0; hz.i_id_rs2_addr = '0;
    hz.i_ex_rd_addr = '0;      hz.i_ex_wr_en = 0;     hz.i_ex_is_load = 0;
    hz.i_mem_rd_addr = '0;     hz.i_mem_wr_en = 0;    hz.i_wb_wr_en = 0;
    hz.i_branch_taken = 0;     hz.i_mem_busy = 0;
    repeat (2) @(posedge clk);
    #1;
    m_mode = 0; m_left = 0; m_pend = 0; m_fa = 2'b00; m_fb = 2'b00;

    step(s, "reset_state");

    // lw x5 in EX, add x6,x5,x1 in ID: one bubble, then forward from MEM/WB
    s = idle(); s.op = OP_REG; s.rs1 = 5; s.rs2 = 1;
    s.ex_rd = 5; s.ex_we = 1; s.ex_ld = 1;
    step(s, "load_use_stall");
    s.ex_rd = 0; s.ex_we = 0; s.ex_ld = 0; s.mem_rd = 5; s.mem_we = 1;
    step(s, "load_use_reissue");
    step(idle(), "load_use_fwd_a_10");

    // add x5 in EX, sub x7,x1,x5 in ID: no stall, fwd_b = 01; then x0 as rd
    s = idle(); s.op = OP_REG; s.rs1 = 1; s.rs2 = 5; s.ex_rd = 5; s.ex_we = 1;
    step(s, "ex_fwd_issue");
    step(idle(), "ex_fwd_b_01");
    s.rs2 = 0; s.ex_rd = 0;
    step(s, "x0_issue");
    step(idle(), "x0_fwd_00");

    // taken branch pulse
    s = idle(); s.taken = 1;
    step(s, "branch_taken");
    repeat (3) step(idle(), "branch_after");

    // busy for three cycles with a taken branch in the first
    s = idle(); s.busy = 1; s.taken = 1;
    step(s, "busy_taken");
    s.taken = 0;
    step(s, "busy_wait1");
    step(s, "busy_wait2");
    repeat (4) step(idle(), "busy_release");

    // reset in the middle of MEM_WAIT
    s = idle(); s.busy = 1;
    step(s, "busy_pre_rst");
    step(s, "busy_pre_rst2");
    s.rst_n = 0;
    step(s, "rst_in_mem_wait");
    step(s, "rst_after_edge");
    step(idle(), "rst_release");

    // busy arriving on the final FLUSH cycle
    s = idle(); s.taken = 1;
    step(s, "flush_start");
    s = idle(); s.busy = 1;
    step(s, "flush_last_busy");
    step(s, "flush_then_wait");
    repeat (3) step(idle(), "flush_wait_done");

    // SYSTEM in ID while MEM and WB still write
    s = idle(); s.op = OP_SYSTEM; s.rs1 = 3; s.mem_we = 1; s.wb_we = 1;
    step(s, "csr_detect");
    s.mem_we = 0;
    step(s, "csr_wb_pending");
    s.wb_we = 0;
    step(s, "csr_clear");
    step(idle(), "csr_after");

    for (int i = 0; i < 3000; i++) step(rand_stim(), "random");

    @(negedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
